// File: rtl/pri_enc_pend.sv
// Pending-request priority encoder: sticky request capture with a valid/ready index output.
// Define PRI_ENC_PEND_RR_EN for round-robin selection; otherwise the highest pending index wins.
module pri_enc_pend #(
    parameter  int N = 8,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic [W-1:0] y,
    output logic         y_valid,
    input  logic         y_ready,
    output logic [N-1:0] pend,
    output logic         ovf
);

    logic [N-1:0] pend_r;
    logic [N-1:0] cap_s;
    logic [N-1:0] grant_mask_s;
    logic [N-1:0] pend_nxt_s;
    logic [W-1:0] y_r;
    logic [W-1:0] sel_idx_s;
    logic         y_valid_r;
    logic         ovf_r;
    logic         slot_open_s;
    logic         load_s;

    // Highest set index of v; zero when v is empty (callers gate on v != 0).
    function automatic logic [W-1:0] hi_index(input logic [N-1:0] v);
        logic [W-1:0] idx;
        logic [N-1:0] sh;
        idx = {W{1'b0}};
        for (int i = 0; i < N; i++) begin
            sh  = v >> i;
            idx = sh[0] ? W'(i) : idx;
        end
        return idx;
    endfunction

`ifdef PRI_ENC_PEND_RR_EN
    logic [W-1:0] last_r;

    // First set bit searching downward from (last - 1) mod N, wrapping 0 -> N-1.
    function automatic logic [W-1:0] rr_index(input logic [N-1:0] v, input logic [W-1:0] last);
        logic [W-1:0] idx;
        logic [N-1:0] sh;
        logic         found;
        int           pos;
        idx   = {W{1'b0}};
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            pos   = (int'(last) + N - k) % N;
            sh    = v >> pos;
            idx   = (!found && sh[0]) ? W'(pos) : idx;
            found = found | sh[0];
        end
        return idx;
    endfunction

    assign sel_idx_s = rr_index(pend_r, last_r);

    // Pointer follows every granted index so the next search starts just below it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_r <= {W{1'b0}};
        end else if (load_s) begin
            last_r <= sel_idx_s;
        end else begin
            last_r <= last_r;
        end
    end
`else
    assign sel_idx_s = hi_index(pend_r);
`endif

    // Slot/grant decode; selection looks only at registered pend, never same-cycle d.
    always_comb begin
        slot_open_s  = !y_valid_r || y_ready;
        load_s       = slot_open_s && (pend_r != {N{1'b0}});
        cap_s        = en ? d : {N{1'b0}};
        grant_mask_s = load_s ? ({{(N-1){1'b0}}, 1'b1} << sel_idx_s) : {N{1'b0}};
        pend_nxt_s   = (pend_r & ~grant_mask_s) | cap_s;
    end

    // State registers; a set on a bit being granted survives (set wins).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_r    <= {N{1'b0}};
            y_r       <= {W{1'b0}};
            y_valid_r <= 1'b0;
            ovf_r     <= 1'b0;
        end else begin
            pend_r <= pend_nxt_s;
            ovf_r  <= |(cap_s & pend_r & ~grant_mask_s);
            if (load_s) begin
                y_r       <= sel_idx_s;
                y_valid_r <= 1'b1;
            end else if (slot_open_s) begin
                y_r       <= y_r;
                y_valid_r <= 1'b0;
            end else begin
                y_r       <= y_r;
                y_valid_r <= y_valid_r;
            end
        end
    end

    assign y       = y_r;
    assign y_valid = y_valid_r;
    assign pend    = pend_r;
    assign ovf     = ovf_r;

endmodule

// File: tb/tb_pri_enc_pend.sv
// Directed self-checking bench for pri_enc_pend (N = 8); expectations follow the
// PRI_ENC_PEND_RR_EN setting of the build.
module tb_pri_enc_pend;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [N-1:0] d;
    logic [W-1:0] y;
    logic         y_valid;
    logic         y_ready;
    logic [N-1:0] pend;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    pri_enc_pend #(.N(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .d       (d),
        .y       (y),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .pend    (pend),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    initial begin
        // Reset with requests held high: reset must win
        rst_n = 1'b0; en = 1'b1; d = 8'hFF; y_ready = 1'b1;
        step(); step();
        check("rst_pend",  64'(pend),    64'h00);
        check("rst_valid", 64'(y_valid), 64'h0);
        check("rst_y",     64'(y),       64'h0);
        check("rst_ovf",   64'(ovf),     64'h0);
        rst_n = 1'b1;
        step();
        check("rel_pend",  64'(pend),    64'hFF);
        check("rel_valid", 64'(y_valid), 64'h0);
        d = 8'h00;
        step();
        check("rel_y7",    64'(y),       64'h7);
        check("rel_pend2", 64'(pend),    64'h7F);
        // Reset discards the in-flight output
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rst2_valid", 64'(y_valid), 64'h0);
        check("rst2_pend",  64'(pend),    64'h00);

        // Fixed-priority drain of 1010_0100
        d = 8'hA4;
        step();
        d = 8'h00;
        check("drn_pend0",  64'(pend),    64'hA4);
        check("drn_valid0", 64'(y_valid), 64'h0);
        step();
        check("drn_y7",     64'({y_valid, y}), 64'hF);
        check("drn_pend1",  64'(pend),    64'h24);
        step();
        check("drn_y5",     64'({y_valid, y}), 64'hD);
        step();
        check("drn_y2",     64'({y_valid, y}), 64'hA);
        check("drn_pend3",  64'(pend),    64'h00);
        step();
        check("drn_empty",  64'({y_valid, y}), 64'h2);

        // Stall: y = 3 held while d[6] arrives
        y_ready = 1'b0; d = 8'h08;
        step();
        d = 8'h00;
        step();
        check("stl_y3",    64'({y_valid, y}), 64'hB);
        d = 8'h40;
        step();
        d = 8'h00;
        check("stl_hold1", 64'({y_valid, y}), 64'hB);
        check("stl_pend6", 64'(pend),         64'h40);
        step();
        check("stl_hold2", 64'({y_valid, y}), 64'hB);
        y_ready = 1'b1;
        step();
        check("stl_y6",    64'({y_valid, y}), 64'hE);
        check("stl_pend0", 64'(pend),         64'h00);
        step();
        check("stl_empty", 64'(y_valid),      64'h0);

        // Overflow while stalled, then set-wins on the grant edge
        y_ready = 1'b0; d = 8'h01;
        step();
        d = 8'h10;
        step();
        check("ovf_y0",    64'({y_valid, y}), 64'h8);
        check("ovf_pre",   64'(ovf),          64'h0);
        check("ovf_pend",  64'(pend),         64'h10);
        step();
        d = 8'h00;
        check("ovf_pulse", 64'(ovf),          64'h1);
        check("ovf_pend1", 64'(pend),         64'h10);
        step();
        check("ovf_clear", 64'(ovf),          64'h0);
        check("ovf_pend2", 64'(pend),         64'h10);
        y_ready = 1'b1; d = 8'h10;
        step();
        d = 8'h00;
        check("sw_y4",     64'({y_valid, y}), 64'hC);
        check("sw_pend",   64'(pend),         64'h10);
        check("sw_noovf",  64'(ovf),          64'h0);
        step();
        check("sw_y4b",    64'({y_valid, y}), 64'hC);
        check("sw_pend0",  64'(pend),         64'h00);
        step();
        check("sw_empty",  64'(y_valid),      64'h0);

        // Enable gating: capture blocked, stalled output untouched
        y_ready = 1'b0; d = 8'h30;
        step();
        d = 8'h00;
        step();
        check("en_y5",     64'({y_valid, y}), 64'hD);
        check("en_pend",   64'(pend),         64'h10);
        en = 1'b0; d = 8'h0F;
        step();
        d = 8'h00; en = 1'b1;
        check("en_gpend",  64'(pend),         64'h10);
        check("en_govf",   64'(ovf),          64'h0);
        check("en_gy",     64'({y_valid, y}), 64'hD);
        y_ready = 1'b1;
        en = 1'b0;
        step();
        check("en_drain",  64'({y_valid, y}), 64'hC);
        step();
        en = 1'b1;
        check("en_empty",  64'(y_valid),      64'h0);

        // Bits 7 and 0 re-pulsed every cycle
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; d = 8'h81;
        step();
        check("rr_pend",   64'(pend),         64'h81);
        step();
        check("rr_y1",     64'({y_valid, y}), 64'hF);
        check("rr_ovf",    64'(ovf),          64'h1);
        step();
`ifdef PRI_ENC_PEND_RR_EN
        check("rr_y2",     64'({y_valid, y}), 64'h8);
        step();
        check("rr_y3",     64'({y_valid, y}), 64'hF);
        step();
        check("rr_y4",     64'({y_valid, y}), 64'h8);
`else
        check("rr_y2",     64'({y_valid, y}), 64'hF);
        step();
        check("rr_y3",     64'({y_valid, y}), 64'hF);
        step();
        check("rr_y4",     64'({y_valid, y}), 64'hF);
`endif
        d = 8'h00;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
